// File: rtl/miim_pkg.sv
// Shared constants, FSM state type and frame builder for the Clause 22 MDIO master.
package miim_pkg;

  localparam logic [1:0] MIIM_ST       = 2'b01;
  localparam logic [1:0] MIIM_OP_WRITE = 2'b01;
  localparam logic [1:0] MIIM_OP_READ  = 2'b10;
  localparam logic [1:0] MIIM_TA_WRITE = 2'b10;
  localparam int         MIIM_FRAME_BITS = 32;
  // Bit positions within the 32-bit frame (ST is bit 0).
  localparam int         MIIM_TA_POS   = 14;
  localparam int         MIIM_DATA_POS = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_FRAME,
    S_DONE
  } miim_state_e;

  // On a read the TA/DATA field is all ones: the line is released there anyway.
  function automatic logic [31:0] miim_frame(input logic       write,
                                             input logic [4:0] phy_addr,
                                             input logic [4:0] regad,
                                             input logic [15:0] wdata);
    logic [31:0] f;
    if (write) f = {MIIM_ST, MIIM_OP_WRITE, phy_addr, regad, MIIM_TA_WRITE, wdata};
    else       f = {MIIM_ST, MIIM_OP_READ, phy_addr, regad, 2'b11, 16'hFFFF};
    return f;
  endfunction

endpackage

// File: rtl/miim_clkgen.sv
// MDC generator: one bit cell is 2*HALF_PERIOD clocks, low half first.
// rise marks the first high cycle, fall marks the last cycle of the cell.
module miim_clkgen #(
  parameter int HALF_PERIOD = 13
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  output logic mdc,
  output logic rise,
  output logic fall
);

  localparam int            CW   = $clog2(2 * HALF_PERIOD);
  localparam logic [CW-1:0] HALF = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(2 * HALF_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // mdc is registered alongside cnt so it always equals (cnt >= HALF).
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (en) begin
      cnt <= cnt_next;
      mdc <= (cnt_next >= HALF);
    end
  end

  assign rise = en && (cnt == HALF);
  assign fall = en && (cnt == LAST);

endmodule

// File: rtl/miim_master.sv
// IEEE 802.3 Clause 22 MDIO/MDC management master, one instance per PHY.
// Handshake: a command is taken on any cycle where cmd_valid && cmd_ready; rsp_valid is a one-cycle pulse with no backpressure.
module miim_master
  import miim_pkg::*;
#(
  parameter int HALF_PERIOD   = 13,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        phy_ready,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [5:0] PRE_LAST   = 6'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [5:0] FRAME_LAST = 6'(MIIM_FRAME_BITS - 1);
  localparam logic [5:0] TA_PREV    = 6'(MIIM_TA_POS - 1);
  localparam logic [5:0] DATA_FIRST = 6'(MIIM_DATA_POS);

  miim_state_e state;
  miim_state_e state_next;

  logic        accept;
  logic        clk_en;
  logic        rise;
  logic        fall;
  logic [5:0]  bit_cnt;
  logic [31:0] shreg;
  logic        write_q;
  logic [15:0] rd_shreg;
  logic        mdio_meta;
  logic        mdio_sync;
  logic [31:0] frame_word;

  assign frame_word = miim_frame(cmd_write, cmd_phy_addr, cmd_reg, cmd_wdata);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    clk_en     = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = phy_ready;
        accept    = cmd_valid && phy_ready;
        if (accept) state_next = (PREAMBLE_BITS > 0) ? S_PREAMBLE : S_FRAME;
      end
      S_PREAMBLE: begin
        clk_en = 1'b1;
        if (fall && bit_cnt == PRE_LAST) state_next = S_FRAME;
      end
      S_FRAME: begin
        clk_en = 1'b1;
        if (fall && bit_cnt == FRAME_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        rsp_valid  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // mdio_i is asynchronous to clk_50.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      mdio_meta <= 1'b1;
      mdio_sync <= 1'b1;
    end else begin
      mdio_meta <= mdio_i;
      mdio_sync <= mdio_meta;
    end
  end

  // New line values are loaded on the last cycle of a cell so they appear on the next cell's first cycle.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      write_q   <= 1'b0;
      rd_shreg  <= '0;
      rsp_rdata <= '0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            write_q  <= cmd_write;
            bit_cnt  <= '0;
            rd_shreg <= '0;
            shreg    <= frame_word;
            mdio_oe  <= 1'b1;
            mdio_o   <= (PREAMBLE_BITS > 0) ? 1'b1 : frame_word[31];
          end
        end
        S_PREAMBLE: begin
          if (fall) begin
            if (bit_cnt == PRE_LAST) begin
              bit_cnt <= '0;
              mdio_o  <= shreg[31];
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        S_FRAME: begin
          if (rise && !write_q && bit_cnt >= DATA_FIRST)
            rd_shreg <= {rd_shreg[14:0], mdio_sync};
          if (fall) begin
            if (bit_cnt == FRAME_LAST) begin
              mdio_o    <= 1'b1;
              mdio_oe   <= 1'b0;
              rsp_rdata <= write_q ? 16'h0000 : rd_shreg;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              shreg   <= {shreg[30:0], 1'b0};
              mdio_o  <= shreg[30];
              mdio_oe <= write_q || (bit_cnt < TA_PREV);
            end
          end
        end
        default: ;
      endcase
    end
  end

  miim_clkgen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clkgen (
    .clk_50 (clk_50),
    .reset_n(reset_n),
    .en     (clk_en),
    .restart(accept),
    .mdc    (mdc),
    .rise   (rise),
    .fall   (fall)
  );

endmodule

// File: tb/tb_miim_master.sv
// Bench for miim_master: two instances (default timing and minimum timing) driven by directed and random commands,
// a behavioural PHY model and a scoreboard that checks completion time, read data and the serial frame.
module tb_miim_master;

  localparam int H0 = 13;
  localparam int P0 = 32;
  localparam int H1 = 2;
  localparam int P1 = 0;

  typedef struct {
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          due;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] got;
    logic [63:0] exp;
  } chk_t;

  // clock / reset
  logic clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;
  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  logic        reset_n[2];
  logic        phy_ready[2];
  logic        cmd_valid[2];
  logic        cmd_write[2];
  logic [4:0]  cmd_phy_addr[2];
  logic [4:0]  cmd_reg[2];
  logic [15:0] cmd_wdata[2];
  logic        cmd_ready[2];
  logic        rsp_valid[2];
  logic [15:0] rsp_rdata[2];
  logic        busy[2];
  logic        mdc[2];
  logic        mdio_o[2];
  logic        mdio_oe[2];
  logic        mdio_i[2];

  logic [15:0] phy_data[2];
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  chk_t        chk_q[$];
  int          total = 0;
  int          bad = 0;

  miim_master #(.HALF_PERIOD(H0), .PREAMBLE_BITS(P0)) dut0 (
    .clk_50(clk_50), .reset_n(reset_n[0]), .phy_ready(phy_ready[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_phy_addr(cmd_phy_addr[0]), .cmd_reg(cmd_reg[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .mdc(mdc[0]), .mdio_o(mdio_o[0]), .mdio_oe(mdio_oe[0]), .mdio_i(mdio_i[0])
  );

  miim_master #(.HALF_PERIOD(H1), .PREAMBLE_BITS(P1)) dut1 (
    .clk_50(clk_50), .reset_n(reset_n[1]), .phy_ready(phy_ready[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_phy_addr(cmd_phy_addr[1]), .cmd_reg(cmd_reg[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .mdc(mdc[1]), .mdio_o(mdio_o[1]), .mdio_oe(mdio_oe[1]), .mdio_i(mdio_i[1])
  );

  function automatic int pre_of(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  function automatic int frame_cycles(input int i);
    return (pre_of(i) + 32) * 2 * ((i == 0) ? H0 : H1);
  endfunction

  function automatic void post(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.got  = got;
    c.exp  = exp;
    chk_q.push_back(c);
  endfunction

  function automatic int exp_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // PHY model: idles high, drives TA '0' then DATA MSB first, each change just after an mdc rise.
  int   pcnt[2] = '{0, 0};
  logic pprev[2] = '{1'b0, 1'b0};
  initial begin
    mdio_i[0] = 1'b1;
    mdio_i[1] = 1'b1;
  end
  always @(negedge clk_50) begin
    int p;
    int k;
    for (int i = 0; i < 2; i++) begin
      if (!busy[i]) begin
        pcnt[i]   = 0;
        pprev[i]  = 1'b0;
        mdio_i[i] = 1'b1;
      end else begin
        if (mdc[i] && !pprev[i]) begin
          p = pre_of(i);
          k = pcnt[i];
          if (k == p + 14)                    mdio_i[i] = 1'b0;
          else if (k >= p + 15 && k <= p + 30) mdio_i[i] = phy_data[i][30 + p - k];
          else                                 mdio_i[i] = 1'b1;
          pcnt[i] = pcnt[i] + 1;
        end
        pprev[i] = mdc[i];
      end
    end
  end

  // scoreboard / monitor
  logic [63:0] obits[2] = '{64'h0, 64'h0};
  logic [63:0] ooe[2]   = '{64'h0, 64'h0};
  int          ncell[2] = '{0, 0};
  logic        mprev[2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic score(input int i);
    exp_t        e;
    logic [63:0] eb;
    logic [63:0] eo;
    logic [63:0] mask;
    logic [31:0] fw;
    logic        keep;
    int          p;
    int          n;
    int          b;
    if (exp_size(i) == 0) begin
      check("unexpected_rsp", 64'd1, 64'd0);
      return;
    end
    if (i == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    p  = pre_of(i);
    n  = p + 32;
    fw = {2'b01, (e.write ? 2'b01 : 2'b10), e.phy, e.regad, 2'b10, e.wdata};
    eb = '0;
    eo = '0;
    mask = '0;
    for (int k = 0; k < n; k++) begin
      b    = k - p;
      keep = e.write || (b < 14);
      if (k < p) eb = {eb[62:0], 1'b1};
      else       eb = {eb[62:0], fw[31 - b]};
      eo   = {eo[62:0], keep};
      mask = {mask[62:0], keep};
    end
    check("rsp_cycle", 64'(cyc), 64'(e.due));
    check("rsp_rdata", 64'(rsp_rdata[i]), 64'(e.rdata));
    check("cell_count", 64'(ncell[i]), 64'(n));
    check("frame_bits", obits[i] & mask, eb & mask);
    check("frame_oe", ooe[i], eo);
  endtask

  always @(negedge clk_50) begin
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      check(c.name, c.got, c.exp);
    end
    for (int i = 0; i < 2; i++) begin
      if (!busy[i]) begin
        ncell[i] = 0;
        mprev[i] = 1'b0;
        obits[i] = '0;
        ooe[i]   = '0;
      end else begin
        if (mdc[i] && !mprev[i]) begin
          obits[i] = {obits[i][62:0], mdio_o[i]};
          ooe[i]   = {ooe[i][62:0], mdio_oe[i]};
          ncell[i] = ncell[i] + 1;
        end
        mprev[i] = mdc[i];
      end
      if (rsp_valid[i]) score(i);
    end
  end

  // driver tasks
  task automatic send(input int i, input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                      input logic [15:0] wd, input logic [15:0] rd, input logic hold, output int t_acc);
    exp_t e;
    int   n;
    bit   got;
    cmd_write[i]    = wr;
    cmd_phy_addr[i] = pa;
    cmd_reg[i]      = ra;
    cmd_wdata[i]    = wd;
    cmd_valid[i]    = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 5000) begin
      @(negedge clk_50);
      if (cmd_ready[i]) got = 1'b1;
      else n++;
    end
    if (!got) begin
      post("accept_timeout", 64'd0, 64'd1);
      cmd_valid[i] = 1'b0;
      t_acc = -1;
      return;
    end
    t_acc = cyc;
    if (!wr) phy_data[i] = rd;
    post("idle_at_accept", {60'd0, mdc[i], mdio_o[i], mdio_oe[i], busy[i]}, 64'b0100);
    e.write = wr;
    e.phy   = pa;
    e.regad = ra;
    e.wdata = wd;
    e.rdata = wr ? 16'h0000 : rd;
    e.due   = t_acc + 1 + frame_cycles(i);
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    @(posedge clk_50);
    #1;
    post("busy_after_accept", {62'd0, busy[i], mdc[i]}, 64'b10);
    if (!hold) cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (exp_size(i) != 0 && n < 4000) begin
      @(negedge clk_50);
      n++;
    end
    if (exp_size(i) != 0) begin
      post("rsp_timeout", 64'(exp_size(i)), 64'd0);
      if (i == 0) exp_q0.delete();
      else        exp_q1.delete();
    end
    @(posedge clk_50);
    #1;
  endtask

  task automatic rand_cmd(input int i, input logic hold, output int t_acc);
    send(i, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
         16'($urandom), hold, t_acc);
  endtask

  // main sequence
  initial begin
    int t1;
    int t2;
    int tr;
    int viol;
    int rises;
    int pulses;
    logic prev;
    for (int i = 0; i < 2; i++) begin
      reset_n[i]      = 1'b0;
      phy_ready[i]    = 1'b1;
      cmd_valid[i]    = 1'b0;
      cmd_write[i]    = 1'b0;
      cmd_phy_addr[i] = '0;
      cmd_reg[i]      = '0;
      cmd_wdata[i]    = '0;
      phy_data[i]     = '0;
    end
    repeat (2) @(negedge clk_50);
    for (int i = 0; i < 2; i++)
      post("reset_state", {42'd0, mdc[i], mdio_o[i], mdio_oe[i], busy[i], rsp_valid[i], rsp_rdata[i]},
           {42'd0, 5'b01000, 16'h0000});
    @(posedge clk_50);
    #1;
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    repeat (2) @(posedge clk_50);
    #1;

    // write PHY 5 reg 0 = 0x1140, then read PHY 5 reg 2 returning 0xBEEF
    send(0, 1'b1, 5'd5, 5'h00, 16'h1140, 16'h0000, 1'b0, t1);
    wait_idle(0);
    send(0, 1'b0, 5'd5, 5'h02, 16'h0000, 16'hBEEF, 1'b0, t1);
    wait_idle(0);

    // back-to-back with cmd_valid held
    send(0, 1'b1, 5'd1, 5'h04, 16'h01E1, 16'h0000, 1'b1, t1);
    send(0, 1'b0, 5'd1, 5'h01, 16'h0000, 16'h796D, 1'b0, t2);
    post("b2b_accept", 64'(t2), 64'(t1 + 1 + frame_cycles(0) + 1));
    wait_idle(0);

    // phy_ready gating
    phy_ready[0]    = 1'b0;
    cmd_valid[0]    = 1'b1;
    cmd_write[0]    = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk_50);
      if (cmd_ready[0] || mdc[0] || busy[0]) viol++;
    end
    post("gated_idle", 64'(viol), 64'd0);
    @(posedge clk_50);
    #1;
    phy_ready[0] = 1'b1;
    tr = cyc;
    send(0, 1'b1, 5'd7, 5'h00, 16'h8000, 16'h0000, 1'b0, t1);
    post("accept_after_ready", 64'(t1), 64'(tr));
    repeat (300) @(posedge clk_50);
    #1;
    phy_ready[0] = 1'b0;
    wait_idle(0);
    phy_ready[0] = 1'b1;

    // reset during cell 40 of a read
    send(0, 1'b0, 5'd5, 5'h03, 16'h0000, 16'h1234, 1'b0, t1);
    rises = 0;
    prev  = 1'b0;
    for (int n = 0; n < 3000 && rises < 41; n++) begin
      @(negedge clk_50);
      if (mdc[0] && !prev) rises++;
      prev = mdc[0];
    end
    post("reached_cell40", 64'(rises), 64'd41);
    reset_n[0] = 1'b0;
    exp_q0.delete();
    #1;
    post("reset_midframe", {59'd0, mdc[0], mdio_o[0], mdio_oe[0], busy[0], rsp_valid[0]}, 64'b01000);
    repeat (3) @(posedge clk_50);
    #1;
    reset_n[0] = 1'b1;
    pulses = 0;
    repeat (2000) begin
      @(negedge clk_50);
      if (rsp_valid[0]) pulses++;
    end
    post("no_rsp_after_reset", 64'(pulses), 64'd0);
    post("rdata_after_reset", 64'(rsp_rdata[0]), 64'd0);
    @(posedge clk_50);
    #1;
    send(0, 1'b0, 5'd2, 5'h1F, 16'h0000, 16'hA5C3, 1'b0, t1);
    wait_idle(0);

    // random commands on the default instance
    for (int j = 0; j < 3; j++) begin
      rand_cmd(0, 1'b0, t1);
      wait_idle(0);
    end

    // minimum timing instance: read reg 3, then random traffic with some back-to-back pairs
    send(1, 1'b0, 5'd5, 5'h03, 16'h0000, 16'h0141, 1'b0, t1);
    wait_idle(1);
    for (int j = 0; j < 12; j++) begin
      if (j % 3 == 0) begin
        rand_cmd(1, 1'b1, t1);
        rand_cmd(1, 1'b0, t2);
        post("b2b_accept_min", 64'(t2), 64'(t1 + 1 + frame_cycles(1) + 1));
      end else begin
        rand_cmd(1, 1'b0, t1);
      end
      wait_idle(1);
    end

    repeat (3) @(negedge clk_50);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/miim_master.md
Name: miim_master

Overview:
- IEEE 802.3 Clause 22 MDIO/MDC management master, so gige_top can read and write the registers of each Ethernet PHY.
- Sits downstream of phy_init: gated by its phy_ready output, it configures the PHY (speed, pass-through mode) after hardware reset.
- The top instantiates one per PHY and drives phy*_gm_mdc directly. The top builds the phy*_gm_mio tristate from mdio_o and mdio_oe.

Parameters:
- HALF_PERIOD, 13, clk_50 cycles per MDC half-period; 13 gives about 1.92 MHz MDC; legal range 2..255.
- PREAMBLE_BITS, 32, number of leading '1' bits per frame; legal range 0..32.

Ports:
- clk_50  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- phy_ready  in  1  from phy_init; commands are accepted only while high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when a command can be accepted.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_phy_addr  in  5  PHYAD.
- cmd_reg  in  5  REGAD.
- cmd_wdata  in  16  write data; ignored on a read.
- rsp_valid  out  1  one-cycle pulse at frame end.
- rsp_rdata  out  16  read data; 0 after a write.
- busy  out  1  a frame is in progress.
- mdc  out  1  management clock.
- mdio_o  out  1  MDIO output value.
- mdio_oe  out  1  MDIO output enable.
- mdio_i  in  1  MDIO pad input (asynchronous).

Behaviour:
- Reset (asynchronous, immediate, including mid-frame): state IDLE, mdc=0, mdio_o=1, mdio_oe=0, busy=0, rsp_valid=0, rsp_rdata=0. A frame interrupted by reset is dropped; no rsp_valid is issued.
- Ready/accept: cmd_ready = (state==IDLE) && phy_ready. A command is accepted on the cycle T where cmd_valid && cmd_ready; the command fields are latched on that cycle.
- Frame bits, MSB first: PREAMBLE_BITS x '1', ST=01, OP (write 01, read 10), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]. TA is '10' on a write; on a read the master releases the line for both TA bits.
- Frame length: N = PREAMBLE_BITS + 32 bit cells. Each cell is 2*HALF_PERIOD cycles: mdc low for the first HALF_PERIOD cycles, high for the second.
- Cell timing: cell k (k = 0..N-1) starts at cycle T+1+k*2*HALF_PERIOD. mdio_o and mdio_oe change only on a cell's first cycle, so the line is stable around the MDC rising edge.
- mdio_oe on a read is 0 from the first TA cell through the end of the frame. mdio_oe is 1 for all other frame cells.
- Read sampling: mdio_i passes through a 2-flop synchronizer. The synchronized value is sampled on the cycle mdc goes 0->1 during the 16 DATA cells and shifted in MSB first. The TA cells are not sampled and the line-hold state is not checked.
- Completion: rsp_valid pulses at cycle T+1+N*2*HALF_PERIOD. rsp_rdata updates on the same cycle and holds until the next completion.
- Idle levels: mdc=0, mdio_o=1, mdio_oe=0.
- Busy: busy is 1 from T+1 through the rsp_valid cycle inclusive. The state returns to IDLE on the cycle after rsp_valid, so the earliest back-to-back accept is rsp_valid cycle + 1.
- States: IDLE -> PREAMBLE (skipped when PREAMBLE_BITS=0) -> FRAME (32-bit shift, 6-bit bit counter) -> DONE (1 cycle, rsp_valid) -> IDLE.
- phy_ready drop mid-frame: the frame completes normally; phy_ready affects acceptance only.
- cmd_valid while not ready: not accepted and not queued; the requester keeps it asserted.
- Divider: the counter runs only while busy and restarts at 0 on accept.

Decomposition:
- Package miim_pkg holds:
  - MIIM_ST = 2'b01
  - MIIM_OP_WRITE = 2'b01, MIIM_OP_READ = 2'b10
  - MIIM_TA_WRITE = 2'b10
  - MIIM_FRAME_BITS = 32
- Sub-module miim_clkgen: counter generating mdc plus one-cycle rise/fall strobes, parameterised by HALF_PERIOD, with enable and sync-restart inputs.

Test Plan:
- Write frame, HALF_PERIOD=13, PREAMBLE_BITS=32: write PHY 5, reg 0x00, data 0x1140.
  - Bits sampled on mdc rising edges = 32x1, 01, 01, 00101, 00000, 10, 0001000101000000.
  - mdio_oe=1 throughout; rsp_valid at T+1665; rsp_rdata=0.
- Read frame: read PHY 5, reg 0x02, with a PHY model driving 0xBEEF after each mdc rise.
  - mdio_oe=0 from TA cell 46 through the end of the frame.
  - rsp_rdata=0xBEEF at T+1665.
- Back-to-back: cmd_valid held with two commands.
  - Second accept exactly one cycle after the first rsp_valid.
  - mdc stays low between frames; busy=0 for exactly that one cycle.
- phy_ready gating:
  - phy_ready=0 with cmd_valid=1 for 100 cycles -> cmd_ready=0, mdc idle.
  - Raise phy_ready -> accept on the next cycle.
  - Drop phy_ready mid-frame -> frame still completes.
- Reset mid-frame: assert reset_n=0 at cell 40 of a read.
  - Same cycle: mdc=0, mdio_oe=0, mdio_o=1, busy=0.
  - No rsp_valid afterwards; a new command then completes correctly.
- Minimum configuration, HALF_PERIOD=2, PREAMBLE_BITS=0: read reg 0x03 -> rsp_valid at T+129 and correct data from the PHY model.
